// File: rtl/operand_issue_pkg.sv
// Shared types for the Ranger RV32 core.
// rv32: machine word types; ranger: decode enums and ID/EX bundle.
package rv32;
  typedef logic [31:0]        word;
  typedef logic signed [31:0] signed_word;
endpackage

package ranger;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_SLTU = 4'd10
  } alu_op_t;

  typedef enum logic [1:0] {
    SRC1_RS1  = 2'd0,
    SRC1_PC   = 2'd1,
    SRC1_ZERO = 2'd2
  } src1_sel_t;

  typedef enum logic [1:0] {
    SRC2_RS2  = 2'd0,
    SRC2_IMM  = 2'd1,
    SRC2_FOUR = 2'd2
  } src2_sel_t;

  typedef struct packed {
    logic             valid;
    alu_op_t          alu_op;
    rv32::signed_word src1;
    rv32::signed_word src2;
    logic [REG_W-1:0] rd;
    logic             rd_we;
    logic             is_load;
    rv32::word        pc;
    rv32::word        store_data;
  } id_ex_t;
endpackage

// File: rtl/operand_issue_fwd_mux.sv
// Per-operand resolver: picks EX/MEM/WB/RF value and flags stalls.
// Without RANGER_OPERAND_FORWARD_EN any in-flight writer stalls.
module fwd_mux
  import ranger::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [XLEN-1:0]       rf_data,
  input  logic                  ex_valid,
  input  logic                  ex_rd_we,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [XLEN-1:0]       ex_data,
  input  logic                  mem_rd_we,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  input  logic                  mem_data_valid,
  input  logic                  wb_rd_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic [XLEN-1:0]       value,
  output logic                  mem_pending,
  output logic                  ex_load_hit
);

  logic nz;
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  // Match the source register against each in-flight writer.
  always_comb begin
    nz      = (rs != REG_ADDR_W'(REG_ZERO));
    ex_hit  = nz & ex_valid & ex_rd_we & (ex_rd == rs);
    mem_hit = nz & mem_rd_we & (mem_rd == rs);
    wb_hit  = nz & wb_rd_we & (wb_rd == rs);
  end

`ifdef RANGER_OPERAND_FORWARD_EN
  logic ex_fwd;

  // Youngest producer wins; a load in EX has no value yet.
  always_comb begin
    ex_fwd      = ex_hit & !ex_is_load;
    ex_load_hit = ex_hit & ex_is_load;
    mem_pending = !ex_fwd & mem_hit & !mem_data_valid;
    value       = '0;
    if (ex_fwd)       value = ex_data;
    else if (mem_hit) value = mem_data;
    else if (wb_hit)  value = wb_data;
    else if (nz)      value = rf_data;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_data, mem_data, wb_data,
                        mem_data_valid, ex_is_load};

  // No bypass: any pending writer of rs stalls until retired.
  always_comb begin
    ex_load_hit = ex_hit;
    mem_pending = mem_hit | wb_hit;
    value       = nz ? rf_data : '0;
  end
`endif

endmodule

// File: rtl/operand_issue.sv
// ID/EX operand issue stage of the Ranger RV32 core.
// Macro RANGER_OPERAND_FORWARD_EN enables EX/MEM/WB bypassing.
module operand_issue
  import ranger::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  dec_valid,
  output logic                  dec_ready,
  input  alu_op_t               dec_alu_op,
  input  src1_sel_t             dec_src1_sel,
  input  src2_sel_t             dec_src2_sel,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  input  logic                  dec_rd_we,
  input  logic                  dec_is_load,
  input  logic [XLEN-1:0]       dec_pc,
  input  logic [XLEN-1:0]       dec_imm,
  input  logic [XLEN-1:0]       rf_rs1_data,
  input  logic [XLEN-1:0]       rf_rs2_data,
  input  logic [XLEN-1:0]       alu_result,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  mem_rd_we,
  input  logic                  wb_rd_we,
  input  logic [XLEN-1:0]       mem_data,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  mem_data_valid,
  input  logic                  ex_ready,
  output logic                  ex_valid,
  output rv32::signed_word      src1,
  output rv32::signed_word      src2,
  output alu_op_t               alu_op,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_rd_we,
  output logic                  ex_is_load,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_store_data
);

  id_ex_t ex_q;
  id_ex_t ex_d;

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic pend1;
  logic pend2;
  logic ld1;
  logic ld2;
  logic use1;
  logic use2;
  logic hazard;
  logic xfer;

  fwd_mux #(
    .XLEN       (XLEN),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_rs1 (
    .rs             (dec_rs1),
    .rf_data        (rf_rs1_data),
    .ex_valid       (ex_q.valid),
    .ex_rd_we       (ex_q.rd_we),
    .ex_is_load     (ex_q.is_load),
    .ex_rd          (ex_q.rd),
    .ex_data        (alu_result),
    .mem_rd_we      (mem_rd_we),
    .mem_rd         (mem_rd),
    .mem_data       (mem_data),
    .mem_data_valid (mem_data_valid),
    .wb_rd_we       (wb_rd_we),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .value          (rs1_val),
    .mem_pending    (pend1),
    .ex_load_hit    (ld1)
  );

  fwd_mux #(
    .XLEN       (XLEN),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_rs2 (
    .rs             (dec_rs2),
    .rf_data        (rf_rs2_data),
    .ex_valid       (ex_q.valid),
    .ex_rd_we       (ex_q.rd_we),
    .ex_is_load     (ex_q.is_load),
    .ex_rd          (ex_q.rd),
    .ex_data        (alu_result),
    .mem_rd_we      (mem_rd_we),
    .mem_rd         (mem_rd),
    .mem_data       (mem_data),
    .mem_data_valid (mem_data_valid),
    .wb_rd_we       (wb_rd_we),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .value          (rs2_val),
    .mem_pending    (pend2),
    .ex_load_hit    (ld2)
  );

  // Stall on used operands only; rs2 under IMM carries store data.
  always_comb begin
    use1      = (dec_src1_sel == SRC1_RS1);
    use2      = (dec_src2_sel == SRC2_RS2) |
                (dec_src2_sel == SRC2_IMM);
    hazard    = (use1 & (ld1 | pend1)) |
                (use2 & (ld2 | pend2));
    dec_ready = (!ex_q.valid | ex_ready) &
                !hazard & !flush & !rst;
    xfer      = dec_valid & dec_ready;
  end

  // Operand source selection for the ALU inputs.
  always_comb begin
    unique case (1'b1)
      dec_src1_sel == SRC1_PC:   op1 = dec_pc;
      dec_src1_sel == SRC1_ZERO: op1 = '0;
      default:                   op1 = rs1_val;
    endcase
    unique case (1'b1)
      dec_src2_sel == SRC2_IMM:  op2 = dec_imm;
      dec_src2_sel == SRC2_FOUR: op2 = XLEN'(4);
      default:                   op2 = rs2_val;
    endcase
  end

  // Next ID/EX contents: flush, load, bubble or hold.
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d.valid  = 1'b0;
      ex_d.alu_op = ALU_NOP;
      ex_d.rd_we  = 1'b0;
    end else if (xfer) begin
      ex_d.valid      = 1'b1;
      ex_d.alu_op     = dec_alu_op;
      ex_d.src1       = op1;
      ex_d.src2       = op2;
      ex_d.rd         = dec_rd;
      ex_d.rd_we      = dec_rd_we;
      ex_d.is_load    = dec_is_load;
      ex_d.pc         = dec_pc;
      ex_d.store_data = rs2_val;
    end else if (ex_ready || !ex_q.valid) begin
      ex_d.valid  = 1'b0;
      ex_d.alu_op = ALU_NOP;
      ex_d.rd_we  = 1'b0;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  assign ex_valid      = ex_q.valid;
  assign src1          = ex_q.src1;
  assign src2          = ex_q.src2;
  assign alu_op        = ex_q.alu_op;
  assign ex_rd         = ex_q.rd;
  assign ex_rd_we      = ex_q.rd_we;
  assign ex_is_load    = ex_q.is_load;
  assign ex_pc         = ex_q.pc;
  assign ex_store_data = ex_q.store_data;

endmodule

// File: tb/tb_operand_issue.sv
// Directed scoreboard bench for operand_issue.
// Expectations follow RANGER_OPERAND_FORWARD_EN when it is defined.
module tb_operand_issue;
  import ranger::*;

  typedef struct {
    alu_op_t     op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  rd;
    logic        we;
    logic        ld;
    logic [31:0] pc;
    logic [31:0] st;
  } exp_t;

  typedef enum int {M_SKIP, M_BUB, M_NEW, M_HOLD} mst_t;

  logic clk = 1'b0;
  logic rst, flush, dec_valid, dec_ready;
  alu_op_t dec_alu_op, alu_op;
  src1_sel_t dec_src1_sel;
  src2_sel_t dec_src2_sel;
  logic [4:0] dec_rs1, dec_rs2, dec_rd, mem_rd, wb_rd, ex_rd;
  logic dec_rd_we, dec_is_load;
  logic [31:0] dec_pc, dec_imm, rf_rs1_data, rf_rs2_data;
  logic [31:0] alu_result, mem_data, wb_data;
  logic mem_rd_we, wb_rd_we, mem_data_valid, ex_ready;
  logic ex_valid, ex_rd_we, ex_is_load;
  rv32::signed_word src1, src2;
  logic [31:0] ex_pc, ex_store_data;

  int n_assert = 0;
  int n_fail   = 0;
  exp_t sb[$];
  exp_t cur;
  exp_t last;
  mst_t mst = M_SKIP;

  operand_issue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_alu_op(dec_alu_op),
    .dec_src1_sel(dec_src1_sel),
    .dec_src2_sel(dec_src2_sel),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rd(dec_rd), .dec_rd_we(dec_rd_we),
    .dec_is_load(dec_is_load),
    .dec_pc(dec_pc), .dec_imm(dec_imm),
    .rf_rs1_data(rf_rs1_data),
    .rf_rs2_data(rf_rs2_data),
    .alu_result(alu_result),
    .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_rd_we(mem_rd_we), .wb_rd_we(wb_rd_we),
    .mem_data(mem_data), .wb_data(wb_data),
    .mem_data_valid(mem_data_valid),
    .ex_ready(ex_ready), .ex_valid(ex_valid),
    .src1(src1), .src2(src2), .alu_op(alu_op),
    .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
    .ex_is_load(ex_is_load), .ex_pc(ex_pc),
    .ex_store_data(ex_store_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, "/valid"}, 32'(ex_valid), 32'd1);
    chk({tag, "/op"},    32'(alu_op), 32'(e.op));
    chk({tag, "/src1"},  src1, e.s1);
    chk({tag, "/src2"},  src2, e.s2);
    chk({tag, "/rd"},    32'(ex_rd), 32'(e.rd));
    chk({tag, "/rd_we"}, 32'(ex_rd_we), 32'(e.we));
    chk({tag, "/load"},  32'(ex_is_load), 32'(e.ld));
    chk({tag, "/pc"},    ex_pc, e.pc);
    chk({tag, "/store"}, ex_store_data, e.st);
  endtask

  task automatic set_ins(input alu_op_t op,
                         input src1_sel_t a,
                         input src2_sel_t b,
                         input logic [4:0] rs1,
                         input logic [4:0] rs2,
                         input logic [4:0] rd,
                         input logic we, input logic ld,
                         input logic [31:0] pc,
                         input logic [31:0] imm);
    dec_valid = 1'b1;
    dec_alu_op = op; dec_src1_sel = a; dec_src2_sel = b;
    dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd;
    dec_rd_we = we; dec_is_load = ld;
    dec_pc = pc; dec_imm = imm;
    cur.op = op; cur.rd = rd; cur.we = we;
    cur.ld = ld; cur.pc = pc;
  endtask

  task automatic expect_ops(input logic [31:0] e1,
                            input logic [31:0] e2,
                            input logic [31:0] est);
    cur.s1 = e1; cur.s2 = e2; cur.st = est;
  endtask

  // One cycle: check outputs of the last edge and dec_ready,
  // then advance the scoreboard model across the next edge.
  task automatic tick(input logic exp_rdy, input string tag);
    @(negedge clk);
    case (mst)
      M_NEW: begin
        n_assert++;
        assert (sb.size() > 0) else begin
          n_fail++;
          $error("FAIL %s/sb: observed empty expected entry",
                 tag);
        end
        if (sb.size() > 0) last = sb.pop_front();
        chk_out(tag, last);
      end
      M_HOLD: chk_out({tag, "/hold"}, last);
      M_BUB: begin
        chk({tag, "/bub_valid"}, 32'(ex_valid), 32'd0);
        chk({tag, "/bub_op"}, 32'(alu_op), 32'(ALU_NOP));
        chk({tag, "/bub_we"}, 32'(ex_rd_we), 32'd0);
      end
      default: ;
    endcase
    chk({tag, "/ready"}, 32'(dec_ready), 32'(exp_rdy));
    if (rst || flush) mst = M_BUB;
    else if (dec_valid && exp_rdy) begin
      sb.push_back(cur);
      mst = M_NEW;
    end else if ((mst == M_NEW || mst == M_HOLD) && !ex_ready)
      mst = M_HOLD;
    else mst = M_BUB;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    mem_rd = '0; wb_rd = '0; mem_rd_we = 1'b0;
    wb_rd_we = 1'b0; mem_data = '0; wb_data = '0;
    mem_data_valid = 1'b1; alu_result = '0;
    rf_rs1_data = 32'h10; rf_rs2_data = 32'h99;
    set_ins(ALU_ADD, SRC1_RS1, SRC2_IMM, 5'd3, 5'd0,
            5'd5, 1'b1, 1'b0, 32'h100, 32'hFFFF_FFFC);
    expect_ops(32'h10, 32'hFFFF_FFFC, 32'h0);

    tick(1'b0, "rst0");
    tick(1'b0, "rst1");
    chk("rst/src1", src1, 32'h0);
    chk("rst/src2", src2, 32'h0);
    chk("rst/pc", ex_pc, 32'h0);
    chk("rst/store", ex_store_data, 32'h0);
    rst = 1'b0;

    tick(1'b1, "plain");

    set_ins(ALU_ADD, SRC1_RS1, SRC2_RS2, 5'd5, 5'd6,
            5'd8, 1'b1, 1'b0, 32'h104, 32'h0);
    rf_rs1_data = 32'h5555; rf_rs2_data = 32'h20;
    alu_result = 32'h1234;
    wb_rd = 5'd5; wb_rd_we = 1'b1; wb_data = 32'hAAAA;
`ifdef RANGER_OPERAND_FORWARD_EN
    expect_ops(32'h1234, 32'h20, 32'h20);
    tick(1'b1, "exfwd");
    wb_rd_we = 1'b0;
`else
    expect_ops(32'h5555, 32'h20, 32'h20);
    tick(1'b0, "ex_stall");
    tick(1'b0, "wb_stall");
    wb_rd_we = 1'b0;
    tick(1'b1, "after_stall");
`endif

    set_ins(ALU_ADD, SRC1_RS1, SRC2_IMM, 5'd1, 5'd0,
            5'd7, 1'b1, 1'b1, 32'h200, 32'h8);
    rf_rs1_data = 32'h200;
    expect_ops(32'h200, 32'h8, 32'h0);
    tick(1'b1, "load");

    set_ins(ALU_ADD, SRC1_RS1, SRC2_FOUR, 5'd7, 5'd0,
            5'd9, 1'b1, 1'b0, 32'h300, 32'h0);
    rf_rs1_data = 32'h7777;
    tick(1'b0, "ld_use");
    mem_rd = 5'd7; mem_rd_we = 1'b1;
    mem_data = 32'hBEEF; mem_data_valid = 1'b0;
    tick(1'b0, "mem_wait");
    mem_data_valid = 1'b1;
`ifdef RANGER_OPERAND_FORWARD_EN
    expect_ops(32'hBEEF, 32'h4, 32'h0);
    tick(1'b1, "mem_fwd");
    mem_rd_we = 1'b0;
`else
    expect_ops(32'h7777, 32'h4, 32'h0);
    tick(1'b0, "mem_stall");
    mem_rd_we = 1'b0;
    wb_rd = 5'd7; wb_rd_we = 1'b1;
    tick(1'b0, "wb7_stall");
    wb_rd_we = 1'b0;
    tick(1'b1, "ld_rf");
`endif

    set_ins(ALU_ADD, SRC1_RS1, SRC2_IMM, 5'd2, 5'd0,
            5'd0, 1'b1, 1'b1, 32'h500, 32'h0);
    rf_rs1_data = 32'h2020;
    expect_ops(32'h2020, 32'h0, 32'h0);
    tick(1'b1, "load_x0");

    set_ins(ALU_AND, SRC1_RS1, SRC2_RS2, 5'd0, 5'd0,
            5'd10, 1'b1, 1'b0, 32'h504, 32'h0);
    rf_rs1_data = 32'h1111; rf_rs2_data = 32'h2222;
    expect_ops(32'h0, 32'h0, 32'h0);
    tick(1'b1, "use_x0");

    ex_ready = 1'b0;
    set_ins(ALU_SUB, SRC1_PC, SRC2_FOUR, 5'd11, 5'd13,
            5'd12, 1'b1, 1'b0, 32'h400, 32'h0);
    rf_rs2_data = 32'h1313;
    expect_ops(32'h400, 32'h4, 32'h1313);
    tick(1'b0, "bp0");
    tick(1'b0, "bp1");
    tick(1'b0, "bp2");
    ex_ready = 1'b1;
    tick(1'b1, "bp_rel");

    ex_ready = 1'b0; flush = 1'b1;
    set_ins(ALU_XOR, SRC1_ZERO, SRC2_FOUR, 5'd0, 5'd0,
            5'd15, 1'b1, 1'b0, 32'h600, 32'h0);
    expect_ops(32'h0, 32'h4, 32'h0);
    tick(1'b0, "flush");
    flush = 1'b0; dec_valid = 1'b0; ex_ready = 1'b1;
    tick(1'b1, "post_flush");

    set_ins(ALU_ADD, SRC1_ZERO, SRC2_FOUR, 5'd0, 5'd0,
            5'd14, 1'b1, 1'b0, 32'h700, 32'h0);
    expect_ops(32'h0, 32'h4, 32'h0);
    tick(1'b1, "wr14");

    set_ins(ALU_ADD, SRC1_RS1, SRC2_IMM, 5'd0, 5'd14,
            5'd0, 1'b0, 1'b0, 32'h704, 32'h40);
    alu_result = 32'hCAFE; rf_rs2_data = 32'h1414;
`ifdef RANGER_OPERAND_FORWARD_EN
    expect_ops(32'h0, 32'h40, 32'hCAFE);
    tick(1'b1, "st_fwd");
`else
    expect_ops(32'h0, 32'h40, 32'h1414);
    tick(1'b0, "st_stall");
    tick(1'b1, "st_rf");
`endif

    dec_valid = 1'b0;
    tick(1'b1, "drain0");
    tick(1'b1, "drain1");
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
